mdio_responder: RTL and testbench

PHY-side MDIO management responder for the network stack: the far end of the `mdio` station-management initiator. It oversamples `mdc` and `mdio_rx` in the `sys_clk` domain and decodes clause-22 frames addressed to `P_PHY_ADDR`. It serves reads from, and applies writes to, a local 32 x 16-bit register file. Local logic can also update registers, for example status bits, and is notified of every accepted MDIO write. Used in loopback benches and as an emulated PHY behind the MAC.

---
 rtl/mdio_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_mdio_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder: oversamples MDC/MDIO in the sys_clk domain
// and serves a 32 x 16-bit register file that local logic can also update.
module mdio_responder #(
    parameter logic [4:0]  P_PHY_ADDR     = 5'd1,
    parameter logic [31:0] P_RO_MASK      = 32'h0,
    parameter int          P_MIN_PREAMBLE = 1
) (
    input  logic        sys_clk_i,
    input  logic        rst_n_i,
    input  logic        mdc_i,
    input  logic        mdio_rx_i,
    output logic        mdio_tx_o,
    output logic        high_z_o,
    input  logic        loc_wr_en_i,
    input  logic [4:0]  loc_wr_addr_i,
    input  logic [15:0] loc_wr_data_i,
    output logic        wr_strobe_o,
    output logic [4:0]  wr_addr_o,
    output logic [15:0] wr_data_o,
    output logic        busy_o,
    output logic        frame_err_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
    } state_t;

    localparam logic [5:0] MinPre = 6'(P_MIN_PREAMBLE);

    logic        mdc_meta_q, mdc_s_q, mdc_d_q, mdio_meta_q, mdio_s_q;
    logic        rise, fall, is_read;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [5:0]  pre_q, pre_d;
    logic [1:0]  op_q, op_d, op_next;
    logic [4:0]  phy_q, phy_d, phy_next;
    logic [4:0]  reg_q, reg_d, reg_next;
    logic [15:0] shift_q, shift_d, data_next;
    logic        tx_q, tx_d, hz_q, hz_d, err_q, err_d, strobe_q, strobe_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] regs_q [32];

    assign rise      = mdc_s_q & ~mdc_d_q;
    assign fall      = ~mdc_s_q & mdc_d_q;
    assign is_read   = (op_q == 2'b10);
    assign op_next   = {op_q[0], mdio_s_q};
    assign phy_next  = {phy_q[3:0], mdio_s_q};
    assign reg_next  = {reg_q[3:0], mdio_s_q};
    assign data_next = {shift_q[14:0], mdio_s_q};

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mdc_meta_q  <= 1'b0;
            mdc_s_q     <= 1'b0;
            mdc_d_q     <= 1'b0;
            mdio_meta_q <= 1'b1;
            mdio_s_q    <= 1'b1;
        end else begin
            mdc_meta_q  <= mdc_i;
            mdc_s_q     <= mdc_meta_q;
            mdc_d_q     <= mdc_s_q;
            mdio_meta_q <= mdio_rx_i;
            mdio_s_q    <= mdio_meta_q;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pre_q    <= '0;
            op_q     <= '0;
            phy_q    <= '0;
            reg_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            hz_q     <= 1'b1;
            err_q    <= 1'b0;
            strobe_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            op_q     <= op_d;
            phy_q    <= phy_d;
            reg_q    <= reg_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            hz_q     <= hz_d;
            err_q    <= err_d;
            strobe_q <= strobe_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // The MDIO commit is assigned last so it overrides a same-cycle local write.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            if (loc_wr_en_i) regs_q[loc_wr_addr_i] <= loc_wr_data_i;
            if (strobe_d) regs_q[waddr_d] <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = (state_q == S_IDLE) ? pre_q : 6'd0;
        op_d     = op_q;
        phy_d    = phy_q;
        reg_d    = reg_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        hz_d     = hz_q;
        err_d    = 1'b0;
        strobe_d = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: if (rise) begin
                if (mdio_s_q) begin
                    if (pre_q != 6'd32) pre_d = pre_q + 6'd1;
                end else if (pre_q >= MinPre) begin
                    state_d = S_ST;
                    cnt_d   = 5'd0;
                    pre_d   = 6'd0;
                end else begin
                    pre_d = 6'd0;
                end
            end
            S_ST: if (rise) begin
                if (mdio_s_q) begin
                    state_d = S_OP;
                    cnt_d   = 5'd1;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_OP: if (rise) begin
                op_d = op_next;
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else if (op_next == 2'b10 || op_next == 2'b01) begin
                    state_d = S_PHYAD;
                    cnt_d   = 5'd4;
                end else begin
                    // Swallow PHYAD + REGAD + TA + DATA of the bad frame.
                    err_d   = 1'b1;
                    state_d = S_SKIP;
                    cnt_d   = 5'd27;
                end
            end
            S_PHYAD: if (rise) begin
                phy_d = phy_next;
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    state_d = S_REGAD;
                    cnt_d   = 5'd4;
                end
            end
            S_REGAD: if (rise) begin
                reg_d = reg_next;
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else if (phy_q != P_PHY_ADDR) begin
                    state_d = S_SKIP;
                    cnt_d   = 5'd17;
                end else begin
                    state_d = S_TA;
                    cnt_d   = 5'd1;
                    if (is_read) shift_d = regs_q[reg_next];
                end
            end
            S_TA: begin
                if (is_read) begin
                    if (fall) begin
                        if (cnt_q != 5'd0) begin
                            cnt_d = cnt_q - 5'd1;
                        end else begin
                            tx_d    = 1'b0;
                            hz_d    = 1'b0;
                            state_d = S_DATA;
                            cnt_d   = 5'd16;
                        end
                    end
                end else if (rise) begin
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = 5'd15;
                    end
                end
            end
            S_DATA: begin
                if (is_read) begin
                    if (fall) begin
                        if (cnt_q != 5'd0) begin
                            tx_d    = shift_q[15];
                            shift_d = {shift_q[14:0], 1'b0};
                            cnt_d   = cnt_q - 5'd1;
                        end else begin
                            tx_d    = 1'b1;
                            hz_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else if (rise) begin
                    shift_d = data_next;
                    if (cnt_q != 5'd0) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        if (!P_RO_MASK[reg_q]) begin
                            strobe_d = 1'b1;
                            waddr_d  = reg_q;
                            wdata_d  = data_next;
                        end
                        state_d = S_IDLE;
                    end
                end
            end
            S_SKIP: if (rise) begin
                if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
                else state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mdio_tx_o   = tx_q;
    assign high_z_o    = hz_q;
    assign wr_strobe_o = strobe_q;
    assign wr_addr_o   = waddr_q;
    assign wr_data_o   = wdata_q;
    assign frame_err_o = err_q;
    assign busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mdio_responder.sv
// Scoreboard bench for mdio_responder: an MDIO initiator model drives frames, a
// register-file model predicts writes, reads and frame errors.
module tb_mdio_responder;
    localparam logic [4:0]  PHY     = 5'd1;
    localparam logic [31:0] RO_MASK = 32'h0000_0004;
    localparam int          MIN_PRE = 4;
    localparam int          HALF    = 8;
    localparam int K_WR = 0, K_RD = 1, K_BADOP = 2, K_BADST = 3;

    logic        sysClk = 1'b0;
    logic        rstN = 1'b0;
    logic        mdc = 1'b0;
    logic        initDrive = 1'b1;
    logic        initBit = 1'b1;
    logic        locWrEn = 1'b0;
    logic [4:0]  locWrAddr = '0;
    logic [15:0] locWrData = '0;
    logic        mdioTx, highZ, wrStrobe, busy, frameErr, mdioLine;
    logic [4:0]  wrAddr;
    logic [15:0] wrData;

    int checks = 0, errors = 0;
    int wrSeen = 0, rdSeen = 0, errSeen = 0, wrExp = 0, rdExp = 0, errExp = 0;
    int abortCount = 0, abortSeen = 0, capN = 0;
    logic [16:0] capBits = '0;
    logic [20:0] wrEntry;
    logic [15:0] modelRegs [32];
    logic [20:0] expWrQ [$];
    logic [15:0] expRdQ [$];
    int          expErrQ [$];

    assign mdioLine = initDrive ? initBit : (highZ ? 1'b1 : mdioTx);

    always #5 sysClk = ~sysClk;

    mdio_responder #(
        .P_PHY_ADDR(PHY), .P_RO_MASK(RO_MASK), .P_MIN_PREAMBLE(MIN_PRE)
    ) dut (
        .sys_clk_i(sysClk), .rst_n_i(rstN), .mdc_i(mdc), .mdio_rx_i(mdioLine),
        .mdio_tx_o(mdioTx), .high_z_o(highZ),
        .loc_wr_en_i(locWrEn), .loc_wr_addr_i(locWrAddr), .loc_wr_data_i(locWrData),
        .wr_strobe_o(wrStrobe), .wr_addr_o(wrAddr), .wr_data_o(wrData),
        .busy_o(busy), .frame_err_o(frameErr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // One MDC period: data changes with the falling edge, sampled on the rise.
    task automatic mdcBit(input logic drive, input logic b, input bit collide);
        mdc = 1'b0;
        initDrive = drive;
        initBit = b;
        repeat (HALF) @(negedge sysClk);
        mdc = 1'b1;
        if (collide) begin
            repeat (2) @(negedge sysClk);
            locWrEn = 1'b1;
            @(negedge sysClk);
            locWrEn = 1'b0;
            repeat (HALF - 3) @(negedge sysClk);
        end else begin
            repeat (HALF) @(negedge sysClk);
        end
    endtask

    task automatic localWrite(input logic [4:0] a, input logic [15:0] d);
        locWrAddr = a;
        locWrData = d;
        locWrEn = 1'b1;
        @(negedge sysClk);
        locWrEn = 1'b0;
        modelRegs[a] = d;
    endtask

    task automatic predict(input int kind, input logic [4:0] phy, input logic [4:0] regA,
                           input logic [15:0] data);
        if (kind == K_BADOP || kind == K_BADST) begin
            expErrQ.push_back(kind);
            errExp++;
        end else if (phy == PHY) begin
            if (kind == K_WR) begin
                if (!RO_MASK[regA]) begin
                    expWrQ.push_back({regA, data});
                    wrExp++;
                    modelRegs[regA] = data;
                end
            end else begin
                expRdQ.push_back(modelRegs[regA]);
                rdExp++;
            end
        end
    endtask

    task automatic applyStimulus(input int kind, input logic [4:0] phy, input logic [4:0] regA,
                                 input logic [15:0] data, input int preLen, input bit collide,
                                 input int abortBit);
        logic [1:0] op;
        predict(kind, phy, regA, data);
        for (int i = 0; i < preLen; i++) mdcBit(1'b1, 1'b1, 1'b0);
        checkOutput("busy before frame", 32'(busy), 0);
        mdcBit(1'b1, 1'b0, 1'b0);
        if (kind == K_BADST) begin
            mdcBit(1'b1, 1'b0, 1'b0);
            return;
        end
        mdcBit(1'b1, 1'b1, 1'b0);
        checkOutput("busy in frame", 32'(busy), 1);
        op = (kind == K_WR) ? 2'b01 : (kind == K_RD) ? 2'b10 : (data[0] ? 2'b11 : 2'b00);
        for (int i = 1; i >= 0; i--) mdcBit(1'b1, op[i], 1'b0);
        for (int i = 4; i >= 0; i--) mdcBit(1'b1, phy[i], 1'b0);
        for (int i = 4; i >= 0; i--) mdcBit(1'b1, regA[i], 1'b0);
        if (kind == K_RD) begin
            for (int i = 0; i < 18; i++) begin
                if (i == abortBit) begin
                    mdc = 1'b0;
                    initDrive = 1'b0;
                    repeat (HALF / 2) @(negedge sysClk);
                    checkOutput("high_z driven before reset", 32'(highZ), 0);
                    rstN = 1'b0;
                    #1;
                    checkOutput("high_z on async reset", 32'(highZ), 1);
                    checkOutput("mdio_tx on async reset", 32'(mdioTx), 1);
                    abortCount++;
                    expRdQ.delete();
                    rdExp = rdSeen;
                    for (int r = 0; r < 32; r++) modelRegs[r] = '0;
                    repeat (3) @(negedge sysClk);
                    rstN = 1'b1;
                    return;
                end
                mdcBit(1'b0, 1'b1, 1'b0);
            end
        end else begin
            mdcBit(1'b1, 1'b1, 1'b0);
            mdcBit(1'b1, 1'b0, 1'b0);
            for (int i = 15; i >= 0; i--) mdcBit(1'b1, data[i], collide && (i == 0));
        end
    endtask

    // Write-commit and frame-error monitor.
    always @(negedge sysClk) begin
        if (wrStrobe) begin
            wrSeen++;
            checkOutput("wr_strobe expected", 32'(expWrQ.size() != 0), 1);
            if (expWrQ.size() != 0) begin
                wrEntry = expWrQ.pop_front();
                checkOutput("wr_addr", 32'(wrAddr), 32'(wrEntry[20:16]));
                checkOutput("wr_data", 32'(wrData), 32'(wrEntry[15:0]));
            end
        end
        if (frameErr) begin
            errSeen++;
            checkOutput("frame_err expected", 32'(expErrQ.size() != 0), 1);
            if (expErrQ.size() != 0) void'(expErrQ.pop_front());
        end
    end

    // Read-data monitor: collects the line while the responder drives it.
    always @(posedge mdc) begin
        if (abortCount != abortSeen) begin
            abortSeen = abortCount;
            capN = 0;
        end else if (!highZ) begin
            capBits = {capBits[15:0], mdioLine};
            capN++;
        end else if (capN != 0) begin
            rdSeen++;
            checkOutput("read drive expected", 32'(expRdQ.size() != 0), 1);
            checkOutput("read drive periods", 32'(capN), 17);
            checkOutput("read TA bit", 32'(capBits[16]), 0);
            if (expRdQ.size() != 0) checkOutput("read data", 32'(capBits[15:0]), 32'(expRdQ.pop_front()));
            capN = 0;
        end
    end

    initial begin
        int          kind, pick, preR;
        logic [4:0]  phyR, regR;
        logic [15:0] dataR;
        for (int i = 0; i < 32; i++) modelRegs[i] = '0;
        repeat (3) @(negedge sysClk);
        checkOutput("reset mdio_tx", 32'(mdioTx), 1);
        checkOutput("reset high_z", 32'(highZ), 1);
        checkOutput("reset wr_strobe", 32'(wrStrobe), 0);
        checkOutput("reset wr_addr", 32'(wrAddr), 0);
        checkOutput("reset wr_data", 32'(wrData), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset frame_err", 32'(frameErr), 0);
        rstN = 1'b1;
        @(negedge sysClk);

        applyStimulus(K_WR, PHY, 5'd4, 16'hA5C3, MIN_PRE, 1'b0, -1);
        applyStimulus(K_RD, PHY, 5'd4, 16'h0, MIN_PRE, 1'b0, -1);
        localWrite(5'd1, 16'h796D);
        applyStimulus(K_RD, PHY, 5'd1, 16'h0, 6, 1'b0, -1);
        applyStimulus(K_RD, 5'd2, 5'd3, 16'h0, 5, 1'b0, -1);
        applyStimulus(K_WR, PHY, 5'd5, 16'h5A5A, MIN_PRE, 1'b0, -1);
        applyStimulus(K_WR, PHY, 5'd2, 16'h1234, 5, 1'b0, -1);
        applyStimulus(K_RD, PHY, 5'd2, 16'h0, MIN_PRE, 1'b0, -1);
        localWrite(5'd2, 16'hBEEF);
        applyStimulus(K_RD, PHY, 5'd2, 16'h0, MIN_PRE, 1'b0, -1);
        applyStimulus(K_BADOP, PHY, 5'd3, 16'hFFFF, MIN_PRE, 1'b0, -1);
        applyStimulus(K_WR, PHY, 5'd6, 16'h0F0F, MIN_PRE, 1'b0, -1);
        applyStimulus(K_BADST, PHY, 5'd0, 16'h0, 40, 1'b0, -1);
        // Three ones then a zero is too short a preamble and must be ignored.
        for (int i = 0; i < 3; i++) mdcBit(1'b1, 1'b1, 1'b0);
        mdcBit(1'b1, 1'b0, 1'b0);
        applyStimulus(K_WR, PHY, 5'd9, 16'hC0DE, MIN_PRE, 1'b0, -1);
        locWrAddr = 5'd7;
        locWrData = 16'h1111;
        applyStimulus(K_WR, PHY, 5'd7, 16'h7777, MIN_PRE, 1'b1, -1);
        applyStimulus(K_RD, PHY, 5'd7, 16'h0, MIN_PRE, 1'b0, -1);
        applyStimulus(K_RD, PHY, 5'd4, 16'h0, MIN_PRE, 1'b0, 9);
        checkOutput("wr_addr after reset", 32'(wrAddr), 0);
        checkOutput("wr_data after reset", 32'(wrData), 0);
        applyStimulus(K_RD, PHY, 5'd4, 16'h0, MIN_PRE, 1'b0, -1);
        applyStimulus(K_RD, PHY, 5'd7, 16'h0, MIN_PRE, 1'b0, -1);

        for (int n = 0; n < 30; n++) begin
            pick  = $urandom_range(0, 9);
            kind  = (pick < 4) ? K_WR : (pick < 8) ? K_RD : (pick == 8) ? K_BADOP : K_BADST;
            phyR  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(2, 31)) : PHY;
            regR  = 5'($urandom_range(0, 7));
            dataR = 16'($urandom);
            preR  = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(MIN_PRE, MIN_PRE + 4);
            if ($urandom_range(0, 3) == 0) localWrite(5'($urandom_range(0, 7)), 16'($urandom));
            applyStimulus(kind, phyR, regR, dataR, preR, 1'b0, -1);
        end

        for (int i = 0; i < 4; i++) mdcBit(1'b1, 1'b1, 1'b0);
        repeat (4) @(negedge sysClk);
        checkOutput("pending writes", 32'(expWrQ.size()), 0);
        checkOutput("pending reads", 32'(expRdQ.size()), 0);
        checkOutput("pending frame errors", 32'(expErrQ.size()), 0);
        checkOutput("write strobe count", 32'(wrSeen), 32'(wrExp));
        checkOutput("read frame count", 32'(rdSeen), 32'(rdExp));
        checkOutput("frame_err count", 32'(errSeen), 32'(errExp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
